pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Parametrised pipeline control unit; generalises the fixed 6-stage stall decoder.
//  Takes per-stage stall requests, an exception flush request and multi-cycle
//  op (div/mul) starts with a run-time latency.
//  Produces per-stage stall and flush masks, a bubble marker and the redirect PC.
//  Sits beside the PC/IF/ID/EX/MEM/WB pipeline registers.
// PARAMETERS
//  NSTAGE      6          number of pipeline stages; bit 0 = PC ... bit NSTAGE-1 = WB
//  MC_STAGE    3          stage index that owns multi-cycle ops (EX)
//  LATW        6          width of multi-cycle latency field
//  FLUSH_MASK  6'b011110  stages cleared on flush (IF..MEM); width NSTAGE
//  PCW         32         PC width
//  PERF_W      32         perf counter width (PIPE_HAZARD_PERF_EN only)
// PORTS
//  clk           in   1        clock, rising edge
//  rst           in   1        reset, synchronous, active-high
//  stall_req_i   in   NSTAGE   per-stage stall request, bit i from stage i
//  mc_start_i    in   1        multi-cycle op issued this cycle (1-cycle pulse)
//  mc_lat_i      in   LATW     total stall cycles for op; 0 = no stall
//  flush_req_i   in   1        exception/eret redirect request
//  flush_pc_i    in   PCW      redirect target, valid with flush_req_i
//  stall_o       out  NSTAGE   stage i holds its register when 1
//  bubble_o      out  NSTAGE   one-hot: stage receives NOP (first non-stalled stage)
//  flush_o       out  NSTAGE   stage i clears its register when 1
//  new_pc_o      out  PCW      redirect PC, valid when flush_o != 0
//  mc_busy_o     out  1        multi-cycle op in progress (state BUSY)
//  mc_done_o     out  1        final stall cycle of multi-cycle op
// BEHAVIOUR
//  - Outputs combinational from inputs and registered state; state updates on clk.
//  - rst high: all outputs 0 the same cycle; next edge: state IDLE, cnt 0.
//  - Effective request r = stall_req_i | (mc_stall << MC_STAGE).
//    mc_stall = (IDLE & mc_start_i & mc_lat_i!=0) | BUSY.
//  - Stall resolution: k = highest set bit of r.
//    stall_o[k:0] = 1, upper bits 0.
//    bubble_o[k+1] = 1 if k+1 < NSTAGE, else bubble_o = 0.
//    r == 0 -> stall_o = 0 and bubble_o = 0.
//    NSTAGE=6: ID req -> 000111, bubble 001000; EX req -> 001111, bubble 010000.
//  - FSM IDLE/BUSY with down-counter cnt (LATW bits):
//    IDLE, mc_start_i, L=mc_lat_i: L=0 -> stay IDLE, no stall.
//      L=1 -> stall this cycle, mc_done_o=1, stay IDLE.
//      L>=2 -> stall, cnt<=L-1, go BUSY.
//    BUSY: stall asserted, cnt<=cnt-1; cnt==1 -> mc_done_o=1, go IDLE.
//    Op stalls exactly L consecutive cycles, start cycle included.
//    mc_start_i while BUSY is ignored; issuing logic must not do it.
//  - Flush has highest priority (flush_req_i=1):
//    flush_o=FLUSH_MASK, stall_o=0, bubble_o=0, mc_done_o=0, new_pc_o=flush_pc_i.
//    FSM forced to IDLE, cnt<=0, which aborts any multi-cycle op.
//    mc_start_i the same cycle is dropped.
//    flush_req_i=0 -> flush_o=0, new_pc_o=0.
//  - Flush and stall requests together: flush wins; stall requests resume next cycle.
//  - mc_lat_i = 2^LATW-1 is legal (max latency); cnt never wraps below 0.
// CONFIGURATION
//  PIPE_HAZARD_PERF_EN defined:
//   - ports stall_cyc_o, flush_cnt_o [PERF_W] added.
//   - stall_cyc_o += 1 each cycle stall_o != 0.
//   - flush_cnt_o += 1 each flush cycle.
//   - both saturate at all-ones and clear on rst.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  - Shared package (pipe_pkg): stage index constants STG_PC..STG_WB,
//    FSM state typedef {IDLE,BUSY}, default FLUSH_MASK.
//  - One sub-module: pipe_prio_mask, a combinational highest-set-bit -> thermometer
//    mask plus one-hot bubble, parametrised by NSTAGE.
// TESTING
//  1. stall_req_i=000100 -> stall_o=000111, bubble_o=001000.
//     Add bit 3 -> 001111, bubble 010000.
//  2. mc_start_i, mc_lat_i=3 at t -> stall_o=001111 at t,t+1,t+2.
//     mc_done_o at t+2; idle at t+3.
//  3. mc_lat_i=0 -> no stall.
//     mc_lat_i=1 -> single stall cycle with mc_done_o.
//     mc_lat_i=63 -> 63 stall cycles.
//  4. flush_req_i at BUSY cycle 2 of L=5, flush_pc_i=32'hBFC00380 ->
//     flush_o=011110, new_pc_o=BFC00380, stall_o=0; next cycle idle.
//  5. rst mid-BUSY -> outputs 0 that cycle; after release no residual stall.
//  6. PERF_EN: 4 stall cycles + 1 flush -> stall_cyc_o=4, flush_cnt_o=1.
//     Force near max -> counters saturate.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard control slice.
//  - Stage index constants for the classic 6-stage PC/IF/ID/EX/MEM/WB pipe.
//  - Multi-cycle FSM state type.
//  - Default flush mask (IF..MEM cleared on a redirect).
package pipe_pkg;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  localparam logic [5:0] FLUSH_MASK_DEF = 6'b011110;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_t;

endpackage

// File: rtl/pipe_prio_mask.sv
// Highest-set-bit resolver for stall requests.
//  req    in  NSTAGE  effective per-stage stall requests
//  stall  out NSTAGE  thermometer mask: bits [k:0] set, k = highest set bit of req
//  bubble out NSTAGE  one-hot at k+1 (first stage that keeps moving), 0 if k is the
//                     last stage or req == 0
// Purely combinational.
module pipe_prio_mask #(
  parameter int NSTAGE = 6
) (
  input  logic [NSTAGE-1:0] req,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] bubble
);

  // A stage stalls if it or any later stage requests a stall: OR-scan from the top.
  generate
    for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_therm
      if (gi == NSTAGE - 1) begin : g_top
        assign stall[gi] = req[gi];
      end else begin : g_rest
        assign stall[gi] = req[gi] | stall[gi+1];
      end
    end
  endgenerate

  // The bubble goes into the stage just above the thermometer edge.
  generate
    for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_bub
      if (gi == 0) begin : g_first
        assign bubble[gi] = 1'b0;
      end else begin : g_edge
        assign bubble[gi] = stall[gi-1] & ~stall[gi];
      end
    end
  endgenerate

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Parametrised pipeline hazard / stall / flush controller.
//  clk, rst          clock (rising edge), synchronous active-high reset
//  stall_req_i       per-stage stall requests (bit 0 = PC ... NSTAGE-1 = WB)
//  mc_start_i        multi-cycle op issued this cycle
//  mc_lat_i          total stall cycles for that op (0 = none)
//  flush_req_i       exception / eret redirect request
//  flush_pc_i        redirect target
//  stall_o           per-stage hold mask
//  bubble_o          one-hot NOP insertion point
//  flush_o           per-stage clear mask
//  new_pc_o          redirect PC (0 when not flushing)
//  mc_busy_o         multi-cycle FSM in BUSY
//  mc_done_o         last stall cycle of a multi-cycle op
// Optional build macro PIPE_HAZARD_PERF_EN adds saturating counters
//  stall_cyc_o (cycles with any stall) and flush_cnt_o (flush cycles).
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int                NSTAGE     = 6,
  parameter int                MC_STAGE   = STG_EX,
  parameter int                LATW       = 6,
  parameter logic [NSTAGE-1:0] FLUSH_MASK = NSTAGE'(FLUSH_MASK_DEF),
  parameter int                PCW        = 32
`ifdef PIPE_HAZARD_PERF_EN
  ,
  parameter int                PERF_W     = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTAGE-1:0] stall_req_i,
  input  logic              mc_start_i,
  input  logic [LATW-1:0]   mc_lat_i,
  input  logic              flush_req_i,
  input  logic [PCW-1:0]    flush_pc_i,
  output logic [NSTAGE-1:0] stall_o,
  output logic [NSTAGE-1:0] bubble_o,
  output logic [NSTAGE-1:0] flush_o,
  output logic [PCW-1:0]    new_pc_o,
  output logic              mc_busy_o,
  output logic              mc_done_o
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cyc_o,
  output logic [PERF_W-1:0] flush_cnt_o
`endif
);

  mc_state_t         state_reg, state_next;
  logic [LATW-1:0]   cnt_reg, cnt_next;
  logic              mc_stall;
  logic              mc_done_raw;
  logic [NSTAGE-1:0] mc_vec;
  logic [NSTAGE-1:0] eff_req;
  logic [NSTAGE-1:0] stall_mask;
  logic [NSTAGE-1:0] bubble_mask;

  // cnt holds the stall cycles still owed after the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    mc_stall    = 1'b0;
    mc_done_raw = 1'b0;
    if (flush_req_i) begin
      // Redirect aborts any op in flight and drops a same-cycle start.
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (mc_start_i && (mc_lat_i != '0)) begin
            mc_stall = 1'b1;
            if (mc_lat_i == LATW'(1)) begin
              mc_done_raw = 1'b1;
            end else begin
              state_next = BUSY;
              cnt_next   = mc_lat_i - LATW'(1);
            end
          end
        end
        BUSY: begin
          mc_stall = 1'b1;
          // <= rather than == keeps the counter from ever wrapping.
          if (cnt_reg <= LATW'(1)) begin
            mc_done_raw = 1'b1;
            state_next  = IDLE;
            cnt_next    = '0;
          end else begin
            cnt_next = cnt_reg - LATW'(1);
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    mc_vec           = '0;
    mc_vec[MC_STAGE] = mc_stall;
  end

  assign eff_req = stall_req_i | mc_vec;

  pipe_prio_mask #(
    .NSTAGE(NSTAGE)
  ) u_prio (
    .req   (eff_req),
    .stall (stall_mask),
    .bubble(bubble_mask)
  );

  // Reset forces every output low in the same cycle; flush overrides stalls.
  assign stall_o   = (rst || flush_req_i) ? '0 : stall_mask;
  assign bubble_o  = (rst || flush_req_i) ? '0 : bubble_mask;
  assign flush_o   = (!rst && flush_req_i) ? FLUSH_MASK : '0;
  assign new_pc_o  = (!rst && flush_req_i) ? flush_pc_i : '0;
  assign mc_busy_o = !rst && (state_reg == BUSY);
  assign mc_done_o = !rst && !flush_req_i && mc_done_raw;

`ifdef PIPE_HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cyc_reg;
  logic [PERF_W-1:0] flush_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cyc_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if ((stall_o != '0) && (stall_cyc_reg != '1)) begin
        stall_cyc_reg <= stall_cyc_reg + PERF_W'(1);
      end
      if (flush_req_i && (flush_cnt_reg != '1)) begin
        flush_cnt_reg <= flush_cnt_reg + PERF_W'(1);
      end
    end
  end

  assign stall_cyc_o = rst ? '0 : stall_cyc_reg;
  assign flush_cnt_o = rst ? '0 : flush_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (6-stage default configuration).
module tb_pipe_hazard_ctrl;

  localparam int NS = 6;
  localparam int LW = 6;
  localparam int PW = 32;
  localparam int QW = 4;
  localparam logic [NS-1:0] FM = 6'b011110;

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] stall_req_i;
  logic          mc_start_i;
  logic [LW-1:0] mc_lat_i;
  logic          flush_req_i;
  logic [PW-1:0] flush_pc_i;
  logic [NS-1:0] stall_o, bubble_o, flush_o;
  logic [PW-1:0] new_pc_o;
  logic          mc_busy_o, mc_done_o;
`ifdef PIPE_HAZARD_PERF_EN
  logic [QW-1:0] stall_cyc_o, flush_cnt_o;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .NSTAGE(NS), .MC_STAGE(3), .LATW(LW), .FLUSH_MASK(FM), .PCW(PW)
`ifdef PIPE_HAZARD_PERF_EN
    , .PERF_W(QW)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .stall_req_i(stall_req_i), .mc_start_i(mc_start_i), .mc_lat_i(mc_lat_i),
    .flush_req_i(flush_req_i), .flush_pc_i(flush_pc_i),
    .stall_o(stall_o), .bubble_o(bubble_o), .flush_o(flush_o),
    .new_pc_o(new_pc_o), .mc_busy_o(mc_busy_o), .mc_done_o(mc_done_o)
`ifdef PIPE_HAZARD_PERF_EN
    , .stall_cyc_o(stall_cyc_o), .flush_cnt_o(flush_cnt_o)
`endif
  );

  typedef struct {
    logic [NS-1:0] req;
    logic [NS-1:0] st;
    logic [NS-1:0] bub;
  } vec_t;

  vec_t vecs[8];

  // Reference model state: stall cycles still owed by the multi-cycle op.
  int rem;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [NS-1:0] req, input logic st, input logic [LW-1:0] lat,
                        input logic fl, input logic [PW-1:0] pc);
    stall_req_i = req;
    mc_start_i  = st;
    mc_lat_i    = lat;
    flush_req_i = fl;
    flush_pc_i  = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Settle, compare every output, then advance one clock.
  task automatic expect_out(input string name, input logic [NS-1:0] st, input logic [NS-1:0] bub,
                            input logic [NS-1:0] fl, input logic [PW-1:0] pc,
                            input logic busy, input logic done);
    #2;
    chk({name, ".stall"}, 64'(stall_o), 64'(st));
    chk({name, ".bubble"}, 64'(bubble_o), 64'(bub));
    chk({name, ".flush"}, 64'(flush_o), 64'(fl));
    chk({name, ".new_pc"}, 64'(new_pc_o), 64'(pc));
    chk({name, ".busy"}, 64'(mc_busy_o), 64'(busy));
    chk({name, ".done"}, 64'(mc_done_o), 64'(done));
    $display("[TB] %s req=%b start=%b lat=%0d flush=%b -> stall=%b bubble=%b flush=%b busy=%b done=%b",
             name, stall_req_i, mc_start_i, mc_lat_i, flush_req_i, stall_o, bubble_o, flush_o,
             mc_busy_o, mc_done_o);
    tick();
  endtask

  // Stall resolution from the rule "everything at or below the highest request holds".
  function automatic void resolve(input int r, output logic [NS-1:0] st, output logic [NS-1:0] bub);
    int k = -1;
    for (int i = 0; i < NS; i++) if (((r >> i) & 1) != 0) k = i;
    if (k < 0) begin
      st = '0; bub = '0;
    end else begin
      st  = NS'((1 << (k + 1)) - 1);
      bub = (k + 1 < NS) ? NS'(1 << (k + 1)) : '0;
    end
  endfunction

  initial begin
    logic [NS-1:0] e_st, e_bub, e_fl;
    logic [PW-1:0] e_pc;
    logic          e_busy, e_done;
    int            nstall, ndone, last_done, cyc;
    logic          r_rst, r_st, r_fl;
    logic [NS-1:0] r_req;
    logic [LW-1:0] r_lat;
    logic [PW-1:0] r_pc;

    vecs[0] = '{6'b000000, 6'b000000, 6'b000000};
    vecs[1] = '{6'b000001, 6'b000001, 6'b000010};
    vecs[2] = '{6'b000100, 6'b000111, 6'b001000};
    vecs[3] = '{6'b001100, 6'b001111, 6'b010000};
    vecs[4] = '{6'b100000, 6'b111111, 6'b000000};
    vecs[5] = '{6'b010001, 6'b011111, 6'b100000};
    vecs[6] = '{6'b101010, 6'b111111, 6'b000000};
    vecs[7] = '{6'b000010, 6'b000011, 6'b000100};

    // Reset: outputs must be low while rst is high, even with requests present.
    rst = 1'b1;
    set_in(6'b001000, 1'b1, 6'd4, 1'b0, 32'h0);
    tick();
    expect_out("reset", '0, '0, '0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    set_in('0, 1'b0, '0, 1'b0, '0);
    expect_out("post_reset", '0, '0, '0, '0, 1'b0, 1'b0);

`ifdef PIPE_HAZARD_PERF_EN
    for (int i = 0; i < 4; i++) begin
      set_in(6'b000001, 1'b0, '0, 1'b0, '0);
      tick();
    end
    set_in('0, 1'b0, '0, 1'b1, 32'h100);
    tick();
    set_in('0, 1'b0, '0, 1'b0, '0);
    #2;
    chk("perf.stall_cyc", 64'(stall_cyc_o), 64'd4);
    chk("perf.flush_cnt", 64'(flush_cnt_o), 64'd1);
    $display("[TB] perf stall_cyc=%0d flush_cnt=%0d", stall_cyc_o, flush_cnt_o);
    tick();
    for (int i = 0; i < 20; i++) begin
      set_in(6'b000100, 1'b0, '0, 1'b0, '0);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      set_in('0, 1'b0, '0, 1'b1, 32'h0);
      tick();
    end
    set_in('0, 1'b0, '0, 1'b0, '0);
    #2;
    chk("perf.stall_sat", 64'(stall_cyc_o), 64'd15);
    chk("perf.flush_sat", 64'(flush_cnt_o), 64'd15);
    $display("[TB] perf saturated stall_cyc=%0d flush_cnt=%0d", stall_cyc_o, flush_cnt_o);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    chk("perf.clear", 64'({stall_cyc_o, flush_cnt_o}), 64'd0);
    tick();
`endif

    // Table-driven stall resolution.
    for (int i = 0; i < 8; i++) begin
      set_in(vecs[i].req, 1'b0, '0, 1'b0, '0);
      expect_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].bub, '0, '0, 1'b0, 1'b0);
    end

    // Latency 3: stalls at t, t+1, t+2, done at t+2, idle at t+3.
    set_in('0, 1'b1, 6'd3, 1'b0, '0);
    expect_out("lat3.t0", 6'b001111, 6'b010000, '0, '0, 1'b0, 1'b0);
    set_in('0, 1'b0, '0, 1'b0, '0);
    expect_out("lat3.t1", 6'b001111, 6'b010000, '0, '0, 1'b1, 1'b0);
    expect_out("lat3.t2", 6'b001111, 6'b010000, '0, '0, 1'b1, 1'b1);
    expect_out("lat3.t3", '0, '0, '0, '0, 1'b0, 1'b0);

    // Latency 0 and 1.
    set_in('0, 1'b1, 6'd0, 1'b0, '0);
    expect_out("lat0", '0, '0, '0, '0, 1'b0, 1'b0);
    set_in('0, 1'b1, 6'd1, 1'b0, '0);
    expect_out("lat1.t0", 6'b001111, 6'b010000, '0, '0, 1'b0, 1'b1);
    set_in('0, 1'b0, '0, 1'b0, '0);
    expect_out("lat1.t1", '0, '0, '0, '0, 1'b0, 1'b0);

    // Maximum latency 63, bounded observation window.
    set_in('0, 1'b1, 6'd63, 1'b0, '0);
    nstall = 0; ndone = 0; last_done = 0;
    for (cyc = 0; cyc < 100; cyc++) begin
      #2;
      if (stall_o == 6'b001111) nstall++;
      if (mc_done_o) begin ndone++; last_done = cyc; end
      tick();
      set_in('0, 1'b0, '0, 1'b0, '0);
      if (stall_o == '0 && nstall > 0) break;
    end
    chk("lat63.stall_cycles", 64'(nstall), 64'd63);
    chk("lat63.done_count", 64'(ndone), 64'd1);
    chk("lat63.done_cycle", 64'(last_done), 64'd62);
    $display("[TB] lat63 stall_cycles=%0d done_count=%0d done_at=%0d", nstall, ndone, last_done);

    // Flush during the second BUSY cycle of a latency-5 op, with a stall request present.
    set_in('0, 1'b1, 6'd5, 1'b0, '0);
    expect_out("fl.t0", 6'b001111, 6'b010000, '0, '0, 1'b0, 1'b0);
    set_in('0, 1'b0, '0, 1'b0, '0);
    expect_out("fl.t1", 6'b001111, 6'b010000, '0, '0, 1'b1, 1'b0);
    set_in(6'b000100, 1'b1, 6'd3, 1'b1, 32'hBFC00380);
    expect_out("fl.t2", '0, '0, 6'b011110, 32'hBFC00380, 1'b1, 1'b0);
    set_in('0, 1'b0, '0, 1'b0, '0);
    expect_out("fl.t3", '0, '0, '0, '0, 1'b0, 1'b0);
    set_in(6'b000100, 1'b0, '0, 1'b0, '0);
    expect_out("fl.resume", 6'b000111, 6'b001000, '0, '0, 1'b0, 1'b0);

    // Reset in the middle of a BUSY op.
    set_in('0, 1'b1, 6'd10, 1'b0, '0);
    expect_out("rb.t0", 6'b001111, 6'b010000, '0, '0, 1'b0, 1'b0);
    set_in('0, 1'b0, '0, 1'b0, '0);
    expect_out("rb.t1", 6'b001111, 6'b010000, '0, '0, 1'b1, 1'b0);
    rst = 1'b1;
    set_in(6'b000010, 1'b0, '0, 1'b1, 32'h1234);
    expect_out("rb.rst", '0, '0, '0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    set_in('0, 1'b0, '0, 1'b0, '0);
    expect_out("rb.after", '0, '0, '0, '0, 1'b0, 1'b0);

    // Randomised traffic against the reference model.
    rem = 0;
    for (int n = 0; n < 400; n++) begin
      r_rst = ($urandom_range(0, 59) == 0);
      r_req = ($urandom_range(0, 2) == 0) ? NS'($urandom) : '0;
      r_st  = ($urandom_range(0, 4) == 0);
      r_lat = ($urandom_range(0, 9) == 0) ? LW'($urandom) : LW'($urandom_range(0, 6));
      r_fl  = ($urandom_range(0, 19) == 0);
      r_pc  = $urandom;
      e_fl = '0; e_pc = '0; e_st = '0; e_bub = '0; e_busy = 1'b0; e_done = 1'b0;
      if (r_rst) begin
        rem = 0;
      end else if (r_fl) begin
        e_fl = FM; e_pc = r_pc; e_busy = (rem > 0);
        rem = 0;
      end else begin
        e_busy = (rem > 0);
        if (rem == 0 && r_st && r_lat != 0) rem = int'(r_lat);
        e_done = (rem == 1);
        resolve(int'(r_req) | ((rem > 0) ? (1 << 3) : 0), e_st, e_bub);
        if (rem > 0) rem--;
      end
      rst = r_rst;
      set_in(r_req, r_st, r_lat, r_fl, r_pc);
      expect_out($sformatf("rand%0d", n), e_st, e_bub, e_fl, e_pc, e_busy, e_done);
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
